// File: rtl/trng_conditioner.sv
// TRNG conditioner: synchronizes a raw entropy bit, samples it on a divided strobe, applies
// von Neumann debiasing, packs bytes and runs a repetition-count health test.
module trng_conditioner #(
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned RCT_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    input  logic       enable,
    output logic [7:0] rnd_data,
    output logic       rnd_valid,
    input  logic       rnd_ready,
    output logic       overrun,
    output logic       fault
);

    localparam int unsigned    DivW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DivW-1:0] DivMax  = DivW'(SAMPLE_DIV - 1);
    localparam logic [7:0]     RunLimit = 8'(RCT_LIMIT);

    typedef enum logic {StIdle, StHaveFirst} debias_state_e;

    logic            sync1_q, sync2_q;
    logic [DivW-1:0] div_q, div_d;
    debias_state_e   state_q, state_d;
    logic            first_q, first_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      run_q, run_d;
    logic            prev_q, prev_d;
    logic            have_prev_q, have_prev_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            fault_q, fault_d;

    logic strobe, sample, emit, byte_done, fault_set, handshake;

    always_comb begin
        strobe      = enable && (div_q == DivMax);
        sample      = sync2_q;
        div_d       = div_q;
        state_d     = state_q;
        first_d     = first_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        run_d       = run_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        fault_d     = fault_q;
        emit        = 1'b0;

        if (!enable) begin
            div_d       = '0;
            state_d     = StIdle;
            shift_d     = '0;
            bit_cnt_d   = '0;
            run_d       = '0;
            have_prev_d = 1'b0;
        end else begin
            div_d = strobe ? '0 : div_q + DivW'(1);
            if (strobe) begin
                unique case (state_q)
                    StIdle: begin
                        first_d = sample;
                        state_d = StHaveFirst;
                    end
                    StHaveFirst: begin
                        state_d = StIdle;
                        emit    = (first_q != sample);
                    end
                endcase
                if (emit) begin
                    shift_d   = {shift_q[6:0], first_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                // First sample after reset or enable rise starts a fresh run.
                if (!have_prev_q || (sample != prev_q)) begin
                    run_d = 8'd1;
                end else if (run_q != 8'hFF) begin
                    run_d = run_q + 8'd1;
                end
                prev_d      = sample;
                have_prev_d = 1'b1;
            end
        end

        byte_done = emit && (bit_cnt_q == 3'd7);
        fault_set = (run_d == RunLimit);
        handshake = valid_q && rnd_ready;

        if (fault_q || fault_set) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
        end else if (byte_done && (!valid_q || handshake)) begin
            data_d  = shift_d;
            valid_d = 1'b1;
        end else begin
            if (byte_done) begin
                overrun_d = 1'b1;
            end
            if (handshake) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            div_q       <= '0;
            state_q     <= StIdle;
            first_q     <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            run_q       <= '0;
            prev_q      <= 1'b0;
            have_prev_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= raw_in;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            state_q     <= state_d;
            first_q     <= first_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            fault_q     <= fault_d;
        end
    end

    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;
    assign overrun   = overrun_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Scoreboard bench: a behavioural model predicts bytes as samples are driven; a negedge
// monitor pops and compares on every output handshake.
module tb_trng_conditioner;

    localparam int unsigned SampleDiv = 4;
    localparam int unsigned RctLimit  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_in;
    logic       enable;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       overrun;
    logic       fault;

    int n_checks = 0;
    int n_fails  = 0;
    int hs_count = 0;

    logic [7:0] exp_q[$];

    // Reference model state
    logic       m_have_first, m_first, m_prev, m_have_prev, m_fault, m_overrun;
    logic [7:0] m_shift;
    int         m_cnt, m_run;

    always #5 clk = ~clk;

    trng_conditioner #(
        .SAMPLE_DIV(SampleDiv),
        .RCT_LIMIT (RctLimit)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (raw_in),
        .enable   (enable),
        .rnd_data (rnd_data),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .overrun  (overrun),
        .fault    (fault)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_have_first = 1'b0;
        m_first      = 1'b0;
        m_shift      = '0;
        m_cnt        = 0;
        m_run        = 0;
        m_prev       = 1'b0;
        m_have_prev  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_fault   = 1'b0;
        m_overrun = 1'b0;
        exp_q.delete();
    endtask

    // Drive one raw sample for a full divider period and predict its effect.
    task automatic drive_sample(input logic b);
        raw_in = b;
        if (!m_have_prev || (b != m_prev)) m_run = 1;
        else if (m_run < 255) m_run++;
        m_prev      = b;
        m_have_prev = 1'b1;
        if (m_run >= RctLimit) begin
            m_fault = 1'b1;
            exp_q.delete();
        end
        if (!m_have_first) begin
            m_first      = b;
            m_have_first = 1'b1;
        end else begin
            m_have_first = 1'b0;
            if (m_first != b) begin
                m_shift = {m_shift[6:0], m_first};
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    if (!m_fault) begin
                        if (exp_q.size() != 0) m_overrun = 1'b1;
                        else exp_q.push_back(m_shift);
                    end
                end
            end
        end
        repeat (SampleDiv) @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic a, input logic b);
        drive_sample(a);
        drive_sample(b);
    endtask

    task automatic stop_enable();
        enable = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rnd_valid === 1'b1 && rnd_ready === 1'b1) begin
            hs_count++;
            if (exp_q.size() == 0) chk("byte_expected", 32'(exp_q.size()), 32'd1);
            else chk("byte_data", {24'h0, rnd_data}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        rnd_ready = 1'b1;
        raw_in    = 1'b0;
        model_reset();

        // Reset with raw toggling and enable high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            raw_in = ~raw_in;
            chk("reset_outputs", {21'h0, rnd_valid, rnd_data, overrun, fault}, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", {21'h0, rnd_valid, rnd_data, overrun, fault}, 32'h0);
        stop_enable();

        // Debias and pack
        hs0    = hs_count;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1);
            pair(1'b1, 1'b0);
        end
        drain("debias_drain");
        chk("debias_bytes", 32'(hs_count - hs0), 32'd1);
        chk("debias_valid_low", {31'h0, rnd_valid}, 32'd0);
        stop_enable();

        // Equal pairs are rejected
        hs0    = hs_count;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pair(1'b0, 1'b0);
            pair(1'b1, 1'b1);
        end
        chk("reject_bytes", 32'(hs_count - hs0), 32'd0);
        chk("reject_fault", {31'h0, fault}, 32'd0);
        chk("reject_valid", {31'h0, rnd_valid}, 32'd0);
        stop_enable();

        // Back-pressure: second byte dropped
        rnd_ready = 1'b0;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1);
            pair(1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            pair(1'b1, 1'b0);
            pair(1'b0, 1'b1);
        end
        chk("bp_overrun", {31'h0, overrun}, {31'h0, m_overrun});
        stop_enable();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {23'h0, rnd_valid, rnd_data}, {23'h0, 1'b1, 8'h55});
        end
        rnd_ready = 1'b1;
        drain("bp_drain");
        chk("bp_valid_low", {31'h0, rnd_valid}, 32'd0);
        chk("bp_overrun_sticky", {31'h0, overrun}, 32'd1);

        // Enable dropped mid-byte
        hs0    = hs_count;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) pair(i[0], ~i[0]);
        stop_enable();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1);
            pair(1'b1, 1'b0);
        end
        drain("en_drain");
        chk("en_bytes", 32'(hs_count - hs0), 32'd1);

        // Reset pulsed mid-byte and mid-pair
        hs0 = hs_count;
        for (int i = 0; i < 5; i++) pair(i[0], ~i[0]);
        drive_sample(1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst_overrun_clear", {31'h0, overrun}, {31'h0, m_overrun});
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1);
            pair(1'b1, 1'b0);
        end
        drain("rst_drain");
        chk("rst_bytes", 32'(hs_count - hs0), 32'd1);
        stop_enable();

        // Repetition-count health test
        hs0    = hs_count;
        enable = 1'b1;
        for (int i = 0; i < RctLimit - 1; i++) drive_sample(1'b1);
        chk("fault_before_limit", {31'h0, fault}, 32'd0);
        drive_sample(1'b1);
        chk("fault_at_limit", {31'h0, fault}, {31'h0, m_fault});
        chk("fault_valid_low", {31'h0, rnd_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1);
            pair(1'b1, 1'b0);
        end
        chk("fault_no_bytes", 32'(hs_count - hs0), 32'd0);
        chk("fault_sticky", {31'h0, fault}, 32'd1);
        chk("fault_valid_stays_low", {31'h0, rnd_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/trng_conditioner.md
TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 16, clock cycles between raw-bit samples (valid range 2..256).
REQ-002 Parameter RCT_LIMIT, default 32, run length of identical raw samples that declares a health fault (valid range 2..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 raw_in  input  1  raw entropy bit from the free-running sampling flip-flop; asynchronous to clk.
REQ-006 enable  input  1  high = sample and condition; low = idle.
REQ-007 rnd_data  output  8  conditioned random byte.
REQ-008 rnd_valid  output  1  rnd_data holds an unconsumed byte.
REQ-009 rnd_ready  input  1  consumer accepts rnd_data when rnd_valid and rnd_ready are both high.
REQ-010 overrun  output  1  sticky; a completed byte was dropped because the output register was full.
REQ-011 fault  output  1  sticky; repetition-count health test failed.

Function
REQ-012 raw_in SHALL pass through a 2-stage synchronizer before any use; sync stages are reset to 0.
REQ-013 Divider counter SHALL count 0..SAMPLE_DIV-1 while enable=1 and wrap to 0; a sample strobe fires in the cycle the counter equals SAMPLE_DIV-1.
REQ-014 On each strobe the synchronized bit SHALL be taken as one raw sample.
REQ-015 Debias FSM SHALL have states IDLE and HAVE_FIRST: IDLE+strobe -> store sample a, go HAVE_FIRST; HAVE_FIRST+strobe -> with second sample b, emit bit a if a!=b, emit nothing if a==b, go IDLE.
REQ-016 Emitted bits SHALL shift into an 8-bit shift register at the LSB (shift left); a 3-bit counter tracks the bits held.
REQ-017 On the 8th emitted bit the assembled byte SHALL load into rnd_data with rnd_valid=1 in the following cycle if the output register is empty or is handshaking in that same cycle; the bit counter then returns to 0.
REQ-018 If the output register is full and not handshaking when a byte completes, the byte SHALL be discarded, overrun set to 1, rnd_data unchanged.
REQ-019 While rnd_valid=1 and rnd_ready=0, rnd_data and rnd_valid SHALL remain stable.
REQ-020 Handshake with no new byte completing: rnd_valid SHALL go 0 next cycle; handshake with a byte completing in the same cycle: new byte loads and rnd_valid stays 1.
REQ-021 Repetition test: each sample is compared with the previous sample; equal -> run counter +1 (saturating), different -> run counter = 1; first sample after reset or enable rise sets run counter = 1.
REQ-022 When the run counter reaches RCT_LIMIT, fault SHALL be set to 1 in the next cycle.
REQ-023 While fault=1: no byte SHALL be loaded, rnd_valid SHALL be forced to 0, any pending byte discarded; fault clears only on reset.
REQ-024 enable=0 SHALL hold the divider at 0, return debias FSM to IDLE, clear the shift register and bit counter, and reset the run counter; an already-valid output byte SHALL remain available for handshake.
REQ-025 Minimum latency from raw_in change to its sample is 2 synchronizer cycles plus divider phase; byte output is registered (1 cycle after the 8th emitted bit).

Reset
REQ-026 With rst_n=0 at a clk edge, all state SHALL clear: rnd_data=8'h00, rnd_valid=0, overrun=0, fault=0, divider=0, FSM=IDLE, bit counter=0, run counter=0, synchronizer=0.
REQ-027 Reset asserted mid-byte or mid-pair SHALL discard all partial state; the first byte after reset is built only from post-reset samples.

Verification
REQ-028 Reset: rst_n=0 for 2 cycles with raw_in toggling, enable=1 -> all outputs 0 throughout and 1 cycle after release.
REQ-029 Debias/pack: SAMPLE_DIV=4, enable=1, rnd_ready=1, raw pairs (0,1),(1,0) alternated 4 times -> single rnd_valid pulse with rnd_data=8'h55.
REQ-030 Rejection: raw pairs (0,0),(1,1) alternated 16 times -> rnd_valid never asserts, fault stays 0.
REQ-031 Back-pressure: rnd_ready=0, enough pairs for two bytes (8'h55 then 8'hAA) -> rnd_data holds 8'h55, second byte dropped, overrun=1; raising rnd_ready -> 8'h55 accepted, rnd_valid drops.
REQ-032 Health: RCT_LIMIT=32, raw_in held 1 -> fault=1 the cycle after the 32nd sample, rnd_valid=0, no further bytes despite later alternating input.
REQ-033 Enable/reset mid-byte: after 5 emitted bits deassert enable (or pulse rst_n low), then resume with 8 fresh alternating pairs -> exactly one byte 8'h55, no stale bits.
